// File: rtl/quiz_round_ctrl.sv
// Mental-math quiz round controller: samples RNG operands/operator, times and judges
// the player's answer, and keeps score and round count across one game.
module quiz_round_ctrl #(
  parameter int unsigned ROUNDS         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rnd_in,
  input  logic       start,
  input  logic       ans_valid,
  input  logic [7:0] ans_in,
  output logic       count_en,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [1:0] op_sel,
  output logic       question_valid,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic       done
);

  localparam int unsigned OPW    = 4;
  localparam int unsigned ANSW   = 8;
  localparam int unsigned CNTW   = 4;
  localparam int unsigned TIMERW = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [TIMERW-1:0] TIMER_LAST = TIMERW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0]   ROUND_LAST = CNTW'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE, SAMP_A, SAMP_B, SAMP_OP, CALC, WAIT_ANS, RESULT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [ANSW-1:0]   expected, expected_nxt;
  logic [TIMERW-1:0] timer, timer_nxt;
  logic [OPW-1:0]    op_a_nxt, op_b_nxt, a_calc, b_calc;
  logic [1:0]        op_sel_nxt;
  logic              correct_nxt, wrong_nxt, timeout_nxt;
  logic              question_valid_nxt, done_nxt;
  logic [CNTW-1:0]   score_nxt, round_nxt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_sel_nxt   = op_sel;
    expected_nxt = expected;
    timer_nxt    = timer;
    score_nxt    = score;
    round_nxt    = round;
    correct_nxt  = 1'b0;
    wrong_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    a_calc       = op_a;
    b_calc       = op_b;

    case (state)
      IDLE: if (start) state_nxt = SAMP_A;
      SAMP_A: begin
        op_a_nxt  = rnd_in;
        state_nxt = SAMP_B;
      end
      SAMP_B: begin
        op_b_nxt  = rnd_in;
        state_nxt = SAMP_OP;
      end
      SAMP_OP: begin
        op_sel_nxt = (rnd_in[1:0] == 2'b11) ? OP_ADD : rnd_in[1:0];
        state_nxt  = CALC;
      end
      CALC: begin
        // Subtraction is ordered so the answer never goes negative
        if (op_sel == OP_SUB && op_a < op_b) begin
          a_calc = op_b;
          b_calc = op_a;
        end
        op_a_nxt = a_calc;
        op_b_nxt = b_calc;
        case (op_sel)
          OP_SUB:  expected_nxt = ANSW'(a_calc) - ANSW'(b_calc);
          OP_MUL:  expected_nxt = ANSW'(a_calc) * ANSW'(b_calc);
          default: expected_nxt = ANSW'(a_calc) + ANSW'(b_calc);
        endcase
        timer_nxt = '0;
        state_nxt = WAIT_ANS;
      end
      WAIT_ANS: begin
        if (ans_valid) begin
          correct_nxt = (ans_in == expected);
          wrong_nxt   = (ans_in != expected);
          state_nxt   = RESULT;
        end else if (timer == TIMER_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = RESULT;
        end else begin
          timer_nxt = timer + TIMERW'(1);
        end
      end
      RESULT: begin
        round_nxt = round + CNTW'(1);
        if (correct) score_nxt = score + CNTW'(1);
        state_nxt = (round_nxt == ROUND_LAST) ? DONE : SAMP_A;
      end
      DONE: begin
        if (start) begin
          score_nxt = '0;
          round_nxt = '0;
          state_nxt = SAMP_A;
        end
      end
      default: state_nxt = IDLE;
    endcase

    question_valid_nxt = (state_nxt == WAIT_ANS);
    done_nxt           = (state_nxt == DONE);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_en       <= 1'b1;
      op_a           <= '0;
      op_b           <= '0;
      op_sel         <= OP_ADD;
      expected       <= '0;
      timer          <= '0;
      question_valid <= 1'b0;
      correct        <= 1'b0;
      wrong          <= 1'b0;
      timeout        <= 1'b0;
      score          <= '0;
      round          <= '0;
      done           <= 1'b0;
    end else begin
      count_en       <= 1'b1;
      op_a           <= op_a_nxt;
      op_b           <= op_b_nxt;
      op_sel         <= op_sel_nxt;
      expected       <= expected_nxt;
      timer          <= timer_nxt;
      question_valid <= question_valid_nxt;
      correct        <= correct_nxt;
      wrong          <= wrong_nxt;
      timeout        <= timeout_nxt;
      score          <= score_nxt;
      round          <= round_nxt;
      done           <= done_nxt;
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl: table of questions with hand-computed
// operands and verdicts, scored through an expectation queue, plus reset corner cases.
module tb_quiz_round_ctrl;

  localparam int unsigned ROUNDS = 3;
  localparam int unsigned TMO    = 4;

  localparam logic [2:0] V_OK  = 3'b001;  // {timeout, wrong, correct}
  localparam logic [2:0] V_BAD = 3'b010;
  localparam logic [2:0] V_TMO = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rnd_in;
  logic       start;
  logic       ans_valid;
  logic [7:0] ans_in;
  logic       count_en;
  logic [3:0] op_a, op_b;
  logic [1:0] op_sel;
  logic       question_valid, correct, wrong, timeout;
  logic [3:0] score, round;
  logic       done;

  always #5 clk = ~clk;

  quiz_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rnd_in(rnd_in), .start(start),
    .ans_valid(ans_valid), .ans_in(ans_in), .count_en(count_en),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .question_valid(question_valid),
    .correct(correct), .wrong(wrong), .timeout(timeout),
    .score(score), .round(round), .done(done)
  );

  typedef struct {
    logic [3:0] ra, rb, rop;
    int         delay;     // idle WAIT_ANS edges before answering; -1 = never answer
    logic [7:0] ans;
    logic [3:0] ea, eb;
    logic [1:0] esel;
    logic [2:0] ev;
  } vec_t;

  typedef struct {
    logic [3:0] ea, eb;
    logic [1:0] esel;
    logic [2:0] ev;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   exp_score = 0;
  int   exp_round = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count_en"}, int'(count_en), 1);
    check({tag, "_op_a"}, int'(op_a), 0);
    check({tag, "_op_b"}, int'(op_b), 0);
    check({tag, "_op_sel"}, int'(op_sel), 0);
    check({tag, "_qv"}, int'(question_valid), 0);
    check({tag, "_verdict"}, int'({timeout, wrong, correct}), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_round"}, int'(round), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
    check("start_score", int'(score), 0);
    check("start_round", int'(round), 0);
    check("start_done", int'(done), 0);
  endtask

  task automatic drive_operands(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rop);
    rnd_in = ra;
    @(negedge clk);
    rnd_in = rb;
    @(negedge clk);
    rnd_in = rop;
    @(negedge clk);
    check("qv_low_calc", int'(question_valid), 0);
    rnd_in = 4'($urandom_range(0, 15));
    @(negedge clk);
  endtask

  // Assumes the DUT is in SAMP_A (first sampling edge is the next posedge)
  task automatic run_q(input vec_t v);
    exp_t e;
    exp_t got;
    e.ea = v.ea; e.eb = v.eb; e.esel = v.esel; e.ev = v.ev;
    sb.push_back(e);
    drive_operands(v.ra, v.rb, v.rop);
    check("qv_high", int'(question_valid), 1);
    check("count_en_run", int'(count_en), 1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual 0 required 1");
      return;
    end
    got = sb.pop_front();
    check("op_a", int'(op_a), int'(got.ea));
    check("op_b", int'(op_b), int'(got.eb));
    check("op_sel", int'(op_sel), int'(got.esel));
    if (v.delay < 0) begin
      repeat (TMO - 1) @(negedge clk);
      check("timeout_early", int'(timeout), 0);
      check("qv_before_expiry", int'(question_valid), 1);
      @(negedge clk);
    end else begin
      repeat (v.delay) @(negedge clk);
      ans_in    = v.ans;
      ans_valid = 1'b1;
      @(negedge clk);
      ans_valid = 1'b0;
    end
    check("verdict", int'({timeout, wrong, correct}), int'(got.ev));
    check("qv_result", int'(question_valid), 0);
    if (got.ev == V_OK) exp_score++;
    exp_round++;
    @(negedge clk);
    check("verdict_one_cycle", int'({timeout, wrong, correct}), 0);
    check("score", int'(score), exp_score);
    check("round", int'(round), exp_round);
    check("done", int'(done), (exp_round == int'(ROUNDS)) ? 1 : 0);
  endtask

  initial begin
    tbl[0] = '{4'd5,  4'd9,  4'd2,  0,  8'd45,  4'd5,  4'd9,  2'd2, V_OK};
    tbl[1] = '{4'd3,  4'd12, 4'd1,  0,  8'd9,   4'd12, 4'd3,  2'd1, V_OK};
    tbl[2] = '{4'd7,  4'd8,  4'd7,  3,  8'd15,  4'd7,  4'd8,  2'd0, V_OK};
    tbl[3] = '{4'd3,  4'd12, 4'd1,  1,  8'd247, 4'd12, 4'd3,  2'd1, V_BAD};
    tbl[4] = '{4'd15, 4'd15, 4'd2,  2,  8'd225, 4'd15, 4'd15, 2'd2, V_OK};
    tbl[5] = '{4'd4,  4'd6,  4'd1,  -1, 8'd0,   4'd6,  4'd4,  2'd1, V_TMO};
    tbl[6] = '{4'd0,  4'd0,  4'd0,  0,  8'd0,   4'd0,  4'd0,  2'd0, V_OK};
    tbl[7] = '{4'd9,  4'd2,  4'd9,  0,  8'd8,   4'd9,  4'd2,  2'd1, V_BAD};
    tbl[8] = '{4'd1,  4'd14, 4'd15, -1, 8'd0,   4'd1,  4'd14, 2'd0, V_TMO};
    tbl[9] = '{4'd6,  4'd7,  4'd12, 0,  8'd13,  4'd6,  4'd7,  2'd0, V_OK};

    reset = 1'b0; start = 1'b0; ans_valid = 1'b0; ans_in = '0; rnd_in = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    check("idle_qv", int'(question_valid), 0);

    // Three full games
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) start_game();
      run_q(tbl[i]);
    end

    // Reset during the second question's answer window
    start_game();
    run_q(tbl[9]);
    drive_operands(4'd2, 4'd3, 4'd0);
    check("qv_before_reset", int'(question_valid), 1);
    #2;
    reset     = 1'b0;
    ans_valid = 1'b1;
    ans_in    = 8'd5;
    #1;
    check_reset_outputs("async");
    repeat (2) @(negedge clk);
    check("no_verdict_in_reset", int'({timeout, wrong, correct}), 0);
    reset     = 1'b1;
    ans_valid = 1'b0;
    @(negedge clk);
    check("idle_after_reset_qv", int'(question_valid), 0);
    check("idle_after_reset_verdict", int'({timeout, wrong, correct}), 0);
    start_game();
    run_q(tbl[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Consumer side of the 4-bit free-running RNG counter: drives its enable and samples its count to build arithmetic questions.
- Holds each question (operand A, operand B, operator) stable for display, accepts the player's answer and judges it.
- Tracks score and round number across one game of ROUNDS questions.
- Sits between the RNG counter and the display / keypad logic of the mental-math game.

Parameters:
- ROUNDS, 8: questions per game; legal range 1..15.
- TIMEOUT_CYCLES, 1000: clock cycles allowed per answer; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- rnd_in  in  4  current RNG counter value.
- start  in  1  game start strobe.
- ans_valid  in  1  player answer strobe, single-cycle.
- ans_in  in  8  player answer, unsigned.
- count_en  out  1  drives the RNG counter enable.
- op_a  out  4  displayed operand A.
- op_b  out  4  displayed operand B.
- op_sel  out  2  operator: 00 add, 01 sub, 10 mul, 11 never driven.
- question_valid  out  1  high while an answer is awaited.
- correct  out  1  one-cycle verdict pulse.
- wrong  out  1  one-cycle verdict pulse.
- timeout  out  1  one-cycle verdict pulse.
- score  out  4  correct answers this game.
- round  out  4  questions completed this game.
- done  out  1  game finished.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; op_a=op_b=0; op_sel=00; score=round=0; count_en=1; every other output 0; timer=0.
- count_en=1 in every state, so the RNG keeps running.
- States: IDLE, SAMP_A, SAMP_B, SAMP_OP, CALC, WAIT_ANS, RESULT, DONE.
- IDLE: start=1 at an edge -> SAMP_A. Call that edge k.
- SAMP_A: at edge k+1, op_a<=rnd_in; -> SAMP_B.
- SAMP_B: at edge k+2, op_b<=rnd_in; -> SAMP_OP.
- SAMP_OP: at edge k+3, op_sel<=rnd_in[1:0], with 11 mapped to 00; -> CALC.
- CALC: at edge k+4:
  - if op_sel=01 and op_a<op_b, swap op_a and op_b, so subtraction never goes negative;
  - expected answer (8-bit register) <= a+b, a-b or a*b on the post-swap operands; maximum 225, no overflow;
  - timer<=0; -> WAIT_ANS.
- WAIT_ANS: question_valid=1; op_a, op_b and op_sel are stable.
  - ans_valid=1 at an edge: compare ans_in with the expected answer; -> RESULT, registering correct or wrong.
  - Otherwise timer increments. When timer reaches TIMEOUT_CYCLES-1 with no ans_valid -> RESULT with timeout.
  - The answer window is exactly TIMEOUT_CYCLES edges.
- ans_valid on the same edge as timer expiry: the answer wins and timeout is not asserted.
- RESULT: exactly one of correct, wrong or timeout is high for this one cycle.
  - score increments on correct only; round increments always.
  - If the new round equals ROUNDS -> DONE, otherwise -> SAMP_A (next question, no start needed).
- DONE: done=1; score and round held. start=1 -> clear score and round, -> SAMP_A.
- Ignored inputs: start outside IDLE/DONE; ans_valid outside WAIT_ANS; an ans_valid that is high for several cycles counts only its first edge in WAIT_ANS.
- Reset asserted mid-question: immediate return to reset values; no verdict pulse is produced.
- score never exceeds round; round never exceeds ROUNDS.

Test Plan:
- Reset, start at edge k, rnd_in=5, 9, 2 on edges k+1..k+3 -> op_a=5, op_b=9, op_sel=10; question_valid rises after edge k+4; ans_in=45 with ans_valid -> correct pulse, score=1, round=1.
- Subtraction swap: rnd_in=3, 12, 1 -> op_a=12, op_b=3, op_sel=01; ans_in=9 -> correct; ans_in=247 -> wrong, score unchanged.
- Operator remap: rnd_in[1:0]=11 with operands 7 and 8 -> op_sel=00; ans_in=15 -> correct.
- TIMEOUT_CYCLES=4, no answer -> timeout pulse exactly 4 edges after entry to WAIT_ANS. Repeat with ans_valid on the 4th edge -> correct or wrong only, no timeout.
- ROUNDS=3 game with verdicts correct, wrong, timeout -> done=1, score=1, round=3; start -> score=0, round=0, new question sampled.
- Reset pulled low in WAIT_ANS -> all outputs at reset values asynchronously; no verdict pulse; start afterwards begins a fresh game.
